// File: rtl/wb_onewire_pkg.sv
// Shared definitions for the Wishbone 1-Wire master: register map, op codes,
// slot timing in microseconds and FSM state encodings.
package wb_onewire_pkg;

    localparam logic [1:0] REG_CMD  = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_DIV  = 2'd3;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_RESET = 2'd1,
        OP_WRITE = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    localparam logic [9:0] T_RST_LOW  = 10'd480;
    localparam logic [9:0] T_PRES_SMP = 10'd70;
    localparam logic [9:0] T_LOW_1    = 10'd6;
    localparam logic [9:0] T_LOW_0    = 10'd60;
    localparam logic [9:0] T_REL_1    = 10'd64;
    localparam logic [9:0] T_REL_0    = 10'd10;
    localparam logic [9:0] T_READ_SMP = 10'd15;
    localparam logic [9:0] T_SLOT     = 10'd70;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_LOW  = 3'd1;
    localparam logic [2:0] ST_RST_REL  = 3'd2;
    localparam logic [2:0] ST_RST_REC  = 3'd3;
    localparam logic [2:0] ST_SLOT_LOW = 3'd4;
    localparam logic [2:0] ST_SLOT_REL = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    // True on the tick that completes `t` microseconds since the state was entered.
    function automatic logic us_reached(input logic tick, input logic [9:0] cnt,
                                        input logic [9:0] t);
        return tick && (cnt == t - 10'd1);
    endfunction

endpackage

// File: rtl/onewire_us_tick.sv
// Microsecond prescaler: pulses us_tick every `div` clocks (0 acts as 1).
// The divisor is latched on restart and at every reload.
module onewire_us_tick (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] div,
    input  logic       restart,
    output logic       us_tick
);

    logic [7:0] cnt;
    logic [7:0] div_q;
    logic [7:0] div_eff;

    assign div_eff = (div == 8'd0) ? 8'd1 : div;
    assign us_tick = (cnt == div_q - 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 8'd0;
            div_q <= 8'd1;
        end else if (restart || us_tick) begin
            cnt   <= 8'd0;
            div_q <= div_eff;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/wb_onewire.sv
// Wishbone slave 1-Wire bus master: bus reset with presence detect and
// LSB-first byte write/read slots on an open-drain line.
module wb_onewire
    import wb_onewire_pkg::*;
#(
    parameter int clk_freq = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    inout  wire         onewire,
    output logic        intr
);

    localparam logic [7:0] DIV_RESET = 8'(clk_freq / 1000000);

    logic [2:0] state, state_next;
    logic [9:0] us_cnt;
    logic       us_tick, restart;
    logic       line_meta, line_sync;
    logic       wb_req, wb_wr, stat_rd, cmd_go;
    logic [1:0] reg_sel;
    logic [31:0] rd_mux;
    logic       irq_en, done, presence, busy;
    logic [7:0] div, tx_data, tx_shift, rx_shift, rx_data;
    op_e        op_q;
    logic [2:0] bit_cnt;
    logic       cur_bit;
    logic [9:0] low_us, rel_us;
    logic       fsm_done, pres_smp, bit_smp, slot_next;
    logic       unused_ok;

    assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:9], wb_sel_i};

    assign reg_sel = wb_adr_i[3:2];
    assign wb_req  = wb_stb_i && wb_cyc_i && !wb_ack_o;
    assign wb_wr   = wb_req && wb_we_i;
    assign cmd_go  = wb_wr && (reg_sel == REG_CMD) && (wb_dat_i[1:0] != 2'd0) && (state == ST_IDLE);
    assign busy    = (state != ST_IDLE) && (state != ST_DONE);
    assign intr    = done && irq_en;

    // Open drain: the master only ever pulls low; an async reset releases at once.
    assign onewire = ((state == ST_RST_LOW) || (state == ST_SLOT_LOW)) ? 1'b0 : 1'bz;

    assign cur_bit = (op_q == OP_READ) || tx_shift[bit_cnt];
    assign low_us  = cur_bit ? T_LOW_1 : T_LOW_0;
    assign rel_us  = (op_q == OP_READ) ? (T_SLOT - T_LOW_1) : (cur_bit ? T_REL_1 : T_REL_0);
    assign restart = (state_next != state);

    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            REG_CMD:  rd_mux = {23'd0, irq_en, 8'd0};
            REG_DATA: rd_mux = {24'd0, rx_data};
            REG_STAT: rd_mux = {29'd0, done, presence, busy};
            default:  rd_mux = {24'd0, div};
        endcase
    end

    always_comb begin
        state_next = state;
        fsm_done   = 1'b0;
        pres_smp   = 1'b0;
        bit_smp    = 1'b0;
        slot_next  = 1'b0;
        case (state)
            ST_IDLE:
                if (cmd_go) state_next = (wb_dat_i[1:0] == OP_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
            ST_RST_LOW:
                if (us_reached(us_tick, us_cnt, T_RST_LOW)) state_next = ST_RST_REL;
            ST_RST_REL:
                if (us_reached(us_tick, us_cnt, T_PRES_SMP)) begin
                    state_next = ST_RST_REC;
                    pres_smp   = 1'b1;
                end
            ST_RST_REC:
                if (us_reached(us_tick, us_cnt, T_RST_LOW - T_PRES_SMP)) begin
                    state_next = ST_DONE;
                    fsm_done   = 1'b1;
                end
            ST_SLOT_LOW:
                if (us_reached(us_tick, us_cnt, low_us)) state_next = ST_SLOT_REL;
            ST_SLOT_REL: begin
                // Read sample lands 15us after the slot's falling edge.
                bit_smp = (op_q == OP_READ) && us_reached(us_tick, us_cnt, T_READ_SMP - T_LOW_1);
                if (us_reached(us_tick, us_cnt, rel_us)) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_DONE;
                        fsm_done   = 1'b1;
                    end else begin
                        state_next = ST_SLOT_LOW;
                        slot_next  = 1'b1;
                    end
                end
            end
            default:
                state_next = ST_IDLE;
        endcase
    end

    onewire_us_tick u_tick (
        .clk     (clk),
        .rst     (rst),
        .div     (div),
        .restart (restart),
        .us_tick (us_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            us_cnt    <= 10'd0;
            line_meta <= 1'b1;
            line_sync <= 1'b1;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= 32'd0;
            stat_rd   <= 1'b0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            presence  <= 1'b0;
            div       <= DIV_RESET;
            tx_data   <= 8'd0;
            tx_shift  <= 8'd0;
            rx_shift  <= 8'd0;
            rx_data   <= 8'd0;
            op_q      <= OP_NOP;
            bit_cnt   <= 3'd0;
        end else begin
            state     <= state_next;
            line_meta <= onewire;
            line_sync <= line_meta;
            if (restart)      us_cnt <= 10'd0;
            else if (us_tick) us_cnt <= us_cnt + 10'd1;

            wb_ack_o <= wb_req;
            stat_rd  <= wb_req && !wb_we_i && (reg_sel == REG_STAT);
            if (wb_req && !wb_we_i) wb_dat_o <= rd_mux;
            if (wb_wr && reg_sel == REG_CMD)  irq_en  <= wb_dat_i[8];
            if (wb_wr && reg_sel == REG_DATA) tx_data <= wb_dat_i[7:0];
            if (wb_wr && reg_sel == REG_DIV)  div     <= wb_dat_i[7:0];

            if (cmd_go) begin
                op_q     <= op_e'(wb_dat_i[1:0]);
                tx_shift <= tx_data;
                bit_cnt  <= 3'd0;
            end else if (slot_next) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // A STAT read clears DONE after its ack, unless a command finishes first.
            if (cmd_go)        done <= 1'b0;
            else if (fsm_done) done <= 1'b1;
            else if (stat_rd)  done <= 1'b0;

            if (pres_smp) presence <= ~line_sync;
            if (bit_smp)  rx_shift <= {line_sync, rx_shift[7:1]};
            if (fsm_done && op_q == OP_READ) rx_data <= rx_shift;
        end
    end

endmodule

// File: tb/tb_wb_onewire.sv
// Bench for wb_onewire: register access, reset/presence, write and read
// slot timing, interrupt behaviour and asynchronous reset mid-slot.
`timescale 1ns/1ps
module tb_wb_onewire;
    localparam logic [31:0] A_CMD  = 32'h0;
    localparam logic [31:0] A_DATA = 32'h4;
    localparam logic [31:0] A_STAT = 32'h8;
    localparam logic [31:0] A_DIV  = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_ack_o;
    logic        intr;
    wire         onewire;

    logic        slave_low = 1'b0;
    int          slave_mode = 0;
    int          us_cyc = 50;
    logic [7:0]  slave_byte = 8'h00;
    int          slave_bit = 0;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];

    int          w, tf, tprev, t0, n_low;
    bit          ok;
    logic [31:0] stat, tmp;
    logic [7:0]  tx_byte;

    pullup (onewire);
    assign onewire = slave_low ? 1'b0 : 1'bz;

    wb_onewire dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_ack_o (wb_ack_o),
        .onewire  (onewire),
        .intr     (intr)
    );

    // clock / cycle counter / watchdog
    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave model: presence pulse after a bus reset, or 0-bits on read slots.
    initial begin
        forever begin
            @(negedge onewire);
            if (slave_mode == 1) begin
                @(posedge onewire);
                repeat (60 * us_cyc) @(posedge clk);
                slave_low = 1'b1;
                repeat (120 * us_cyc) @(posedge clk);
                slave_low = 1'b0;
            end else if (slave_mode == 2) begin
                if (!slave_byte[slave_bit[2:0]]) begin
                    slave_low = 1'b1;
                    repeat (30 * us_cyc) @(posedge clk);
                    slave_low = 1'b0;
                end
                slave_bit++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             output logic [31:0] rdata);
        int  n = 0;
        bit  seen = 0;
        rdata = '0;
        @(posedge clk); #1;
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        while (!seen && n < 8) begin
            @(negedge clk);
            if (wb_ack_o) begin
                seen  = 1;
                rdata = wb_dat_o;
            end
            n++;
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        check("ack_width", 32'(wb_ack_o), 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        wb_access(1'b1, adr, dat, d);
    endtask

    // Scoreboard read: expectation queued at issue, compared when the ack delivers data.
    task automatic reg_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        exp_q.push_back(exp);
        wb_access(1'b0, adr, 32'd0, r);
        check(tag, r, exp_q.pop_front());
    endtask

    task automatic measure_low(output int width, output int t_fall, output bit good,
                               input int fall_limit, input int width_limit);
        int n = 0;
        width = 0; t_fall = 0; good = 0;
        do begin
            @(negedge clk);
            n++;
        end while (onewire !== 1'b0 && n < fall_limit);
        if (onewire !== 1'b0) return;
        t_fall = cyc;
        do begin
            width++;
            @(negedge clk);
        end while (onewire === 1'b0 && width < width_limit);
        good = (onewire === 1'b1);
    endtask

    task automatic poll_idle(output logic [31:0] st, output int t_done);
        int k = 0;
        st = 32'h1;
        while (st[0] && k < 4000) begin
            repeat (16) @(posedge clk);
            wb_access(1'b0, A_STAT, 32'd0, st);
            k++;
        end
        t_done = cyc;
        check("poll_busy_clears", 32'(st[0]), 32'd0);
    endtask

    initial begin
        // 1. reset values
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_line", 32'(onewire), 32'd1);
        reg_read("rst_div", A_DIV, 32'h32);
        reg_read("rst_stat", A_STAT, 32'h0);
        reg_read("rst_cmd", A_CMD, 32'h0);
        reg_read("rst_data", A_DATA, 32'h0);

        // 2a. bus reset with presence at DIV=50
        slave_mode = 1; us_cyc = 50;
        fork
            wb_write(A_CMD, 32'h1);
            measure_low(w, tf, ok, 50, 100000);
        join
        check("rst_low_clks", 32'(w), 32'd24000);
        poll_idle(stat, t0);
        check("rst_done_pres", stat, 32'h6);
        check("rst_total_960us", 32'((t0 - tf) >= 48000 && (t0 - tf) <= 48040), 32'd1);
        reg_read("rst_done_cleared", A_STAT, 32'h2);
        slave_mode = 0;

        // 2b. no slave, DIV=5
        wb_write(A_DIV, 32'h5);
        reg_read("div_wr", A_DIV, 32'h5);
        us_cyc = 5;
        wb_write(A_CMD, 32'h1);
        poll_idle(stat, t0);
        check("noslave_stat", stat, 32'h4);

        // 3. write byte 0xA5
        tx_byte = 8'hA5;
        wb_write(A_DATA, {24'd0, tx_byte});
        fork
            wb_write(A_CMD, 32'h2);
            begin
                for (int i = 0; i < 8; i++) begin
                    measure_low(w, tf, ok, 2000, 2000);
                    check($sformatf("wr_low_%0d", i), 32'(w), 32'((tx_byte[i] ? 6 : 60) * us_cyc));
                    if (i > 0) check($sformatf("wr_period_%0d", i), 32'(tf - tprev), 32'(70 * us_cyc));
                    tprev = tf;
                end
            end
        join
        poll_idle(stat, t0);
        check("wr_done", stat, 32'h4);

        // DIV=0 behaves as one clock per microsecond
        wb_write(A_DIV, 32'h0);
        reg_read("div_zero", A_DIV, 32'h0);
        wb_write(A_DATA, 32'hFF);
        fork
            wb_write(A_CMD, 32'h2);
            begin
                for (int i = 0; i < 2; i++) begin
                    measure_low(w, tf, ok, 200, 200);
                    check($sformatf("div0_low_%0d", i), 32'(w), 32'd6);
                    if (i > 0) check("div0_period", 32'(tf - tprev), 32'd70);
                    tprev = tf;
                end
            end
        join
        poll_idle(stat, t0);
        check("div0_done", stat, 32'h4);
        wb_write(A_DIV, 32'h5);

        // 4. read byte 0x3C
        slave_mode = 2; slave_byte = 8'h3C; slave_bit = 0;
        wb_write(A_CMD, 32'h3);
        poll_idle(stat, t0);
        check("rd_done", stat, 32'h4);
        reg_read("rd_data", A_DATA, {24'd0, slave_byte});
        reg_read("rd_stat_cleared", A_STAT, 32'h0);
        slave_mode = 0;

        // 5. IRQ_EN with reset op, then an ignored write op while busy
        wb_write(A_CMD, 32'h101);
        t0 = cyc;
        wb_write(A_CMD, 32'h102);
        check("intr_low_busy", 32'(intr), 32'd0);
        w = 0;
        while (!intr && w < 10000) begin
            @(negedge clk);
            w++;
        end
        check("intr_rise", 32'(intr), 32'd1);
        check("intr_timing", 32'((cyc - t0) >= 4780 && (cyc - t0) <= 4810), 32'd1);
        reg_read("irq_cmd", A_CMD, 32'h100);
        reg_read("irq_stat", A_STAT, 32'h4);
        check("intr_fall", 32'(intr), 32'd0);
        n_low = 0;
        repeat (800) begin
            @(negedge clk);
            if (onewire === 1'b0) n_low++;
        end
        check("ignored_op_quiet", 32'(n_low), 32'd0);
        wb_write(A_CMD, 32'h0);

        // 6. asynchronous reset mid write-0 slot
        wb_write(A_DATA, 32'h0);
        wb_write(A_CMD, 32'h2);
        repeat (100) @(negedge clk);
        check("pre_rst_low", 32'(onewire), 32'd0);
        #3 rst = 1'b0;
        #1;
        check("rst_async_release", 32'(onewire), 32'd1);
        check("rst_async_ack", 32'(wb_ack_o), 32'd0);
        check("rst_async_dat", wb_dat_o, 32'd0);
        check("rst_async_intr", 32'(intr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        reg_read("rst2_div", A_DIV, 32'h32);
        reg_read("rst2_stat", A_STAT, 32'h0);
        reg_read("rst2_data", A_DATA, 32'h0);
        reg_read("rst2_cmd", A_CMD, 32'h0);
        wb_write(A_DIV, 32'h5);
        slave_mode = 1; us_cyc = 5;
        fork
            wb_write(A_CMD, 32'h1);
            measure_low(w, tf, ok, 50, 10000);
        join
        check("rst2_low_clks", 32'(w), 32'd2400);
        poll_idle(stat, t0);
        check("rst2_done_pres", stat, 32'h6);
        reg_read("rst2_cleared", A_STAT, 32'h2);
        slave_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
